mult_scheduler: RTL and testbench

//  Shares one sequential shift-add multiplier between N_REQ requesters.
//  - Round-robin arbitration between requesters.
//  - Drives the multiplier's start/operand inputs and waits for its done pulse.
//  - Returns the product to the winning requester over a valid/ready response channel.
//  - A watchdog aborts a stuck multiplication.

---
 rtl/mult_sched_pkg.sv | 16 +
 rtl/mult_scheduler_rr_arbiter.sv | 38 +++
 rtl/mult_scheduler.sv | 133 +++++++++++++
 tb/tb_mult_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the multiplier scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    // Low bit of requester idx's operand slice in a packed operand bus.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mult_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        idx       = '0;
        // Scan from the farthest offset down so the nearest requester is the last to win.
        for (int off = N_REQ - 1; off >= 0; off--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(off);
            if (sum >= (IDX_W + 1)'(N_REQ))
                sum = sum - (IDX_W + 1)'(N_REQ);
            idx = sum[IDX_W-1:0];
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one sequential multiplier between N_REQ requesters with round-robin
// arbitration, a valid/ready response channel and a watchdog abort.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_x,
    input  logic [N_REQ*WIDTH-1:0]   req_y,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_product,
    output logic                     rsp_err,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_x,
    output logic [WIDTH-1:0]         mul_y,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_product
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    sched_state_t       state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, owner, grant_idx;
    logic [N_REQ-1:0]   grant;
    logic               grant_any;
    logic [WIDTH-1:0]   x_q, y_q;
    logic [WD_W-1:0]    wd;
    logic [2*WIDTH-1:0] prod_q;
    logic               err_q;
    logic               wd_expire, owner_ack;
    logic [WIDTH-1:0]   x_arr [N_REQ];
    logic [WIDTH-1:0]   y_arr [N_REQ];

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            x_arr[i] = req_x[slice_lo(i, WIDTH) +: WIDTH];
            y_arr[i] = req_y[slice_lo(i, WIDTH) +: WIDTH];
        end
    end

    // Abort on the cycle whose increment would bring the watchdog to TIMEOUT-1.
    assign wd_expire = (wd == WD_W'(TIMEOUT - 2));
    assign owner_ack = rsp_ready[owner];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (grant_any) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (mul_done || wd_expire) state_nxt = RESP;
            RESP:  if (owner_ack) state_nxt = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr <= '0;
            owner  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            wd     <= '0;
            prod_q <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (grant_any) begin
                    x_q   <= x_arr[grant_idx];
                    y_q   <= y_arr[grant_idx];
                    owner <= grant_idx;
                end
                ISSUE: wd <= '0;
                WAIT: begin
                    if (mul_done) begin
                        prod_q <= mul_product;
                        err_q  <= 1'b0;
                    end else if (wd_expire) begin
                        prod_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: if (owner_ack)
                    rr_ptr <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
            endcase
        end
    end

    // req_ready is combinational, so it is also gated by reset to keep outputs quiet while held.
    always_comb begin
        req_ready   = '0;
        mul_start   = 1'b0;
        rsp_valid   = '0;
        rsp_product = '0;
        rsp_err     = 1'b0;
        unique case (state)
            IDLE:  if (rst_in) req_ready = grant;
            ISSUE: mul_start = 1'b1;
            WAIT:  ;
            RESP: begin
                rsp_valid[owner] = 1'b1;
                rsp_product      = prod_q;
                rsp_err          = err_q;
            end
        endcase
    end

    assign mul_x = x_q;
    assign mul_y = y_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Randomized self-checking bench for mult_scheduler; the bench also plays the multiplier.
module tb_mult_scheduler;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int TO = 16;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b0;
    logic [N-1:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [N*W-1:0] req_x = '0, req_y = '0;
    logic [2*W-1:0] rsp_product, mul_product = '0;
    logic           rsp_err, mul_start, mul_done = 1'b0;
    logic [W-1:0]   mul_x, mul_y;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending operations per requester and the round-robin pointer.
    int px [N];
    int py [N];
    bit pend [N];
    int model_ptr = 0;

    always #5 clk_in = ~clk_in;

    mult_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_err     (rsp_err),
        .mul_start   (mul_start),
        .mul_x       (mul_x),
        .mul_y       (mul_y),
        .mul_done    (mul_done),
        .mul_product (mul_product)
    );

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic int exp_grant();
        for (int off = 0; off < N; off++)
            if (pend[(model_ptr + off) % N]) return (model_ptr + off) % N;
        return -1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = pend[i];
            req_x[i*W +: W]   = W'(px[i]);
            req_y[i*W +: W]   = W'(py[i]);
        end
    endtask

    task automatic clear_pend();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive_reqs();
    endtask

    // One full operation from grant to accepted response. lat = WAIT cycle that carries
    // mul_done (1..TO-1); any other value means the multiplier never answers.
    task automatic run_txn(input int lat, input int bp, input bit keep, input bit spur);
        int g, ex, ey, exp_p, rsp_k;
        bit exp_err;
        logic [N-1:0] oh;
        drive_reqs();
        #1;
        g = exp_grant();
        if (g < 0) begin
            $display("FAIL txn_setup: no pending requester");
            $fatal(1);
        end
        oh = N'(1) << g;
        checks++;
        if (req_ready !== oh) begin
            failures++;
            $display("FAIL grant: req_ready=%b expected %b (ptr %0d)", req_ready, oh, model_ptr);
        end
        ex = px[g];
        ey = py[g];
        if (lat >= 1 && lat <= TO - 1) begin
            rsp_k = lat + 1; exp_p = ex * ey; exp_err = 1'b0;
        end else begin
            rsp_k = TO; exp_p = 0; exp_err = 1'b1;
        end
        @(negedge clk_in);
        if (keep) begin
            px[g] = $urandom_range(0, (1 << W) - 1);
            py[g] = $urandom_range(0, (1 << W) - 1);
        end else begin
            pend[g] = 1'b0;
        end
        drive_reqs();
        #1;
        checks++;
        if ({mul_start, mul_x, mul_y, req_ready} !== {1'b1, W'(ex), W'(ey), N'(0)}) begin
            failures++;
            $display("FAIL issue: start=%b x=%0d y=%0d ready=%b expected start=1 x=%0d y=%0d ready=0",
                     mul_start, mul_x, mul_y, req_ready, ex, ey);
        end
        for (int k = 1; k < rsp_k; k++) begin
            @(negedge clk_in);
            mul_done    = (k == lat);
            mul_product = (k == lat) ? 8'(ex * ey) : 8'($urandom);
            #1;
            checks++;
            if ({rsp_valid, mul_start, req_ready, mul_x, mul_y} !== {N'(0), 1'b0, N'(0), W'(ex), W'(ey)}) begin
                failures++;
                $display("FAIL wait_cycle_%0d: rsp_valid=%b start=%b ready=%b x=%0d y=%0d expected 0/0/0/%0d/%0d",
                         k, rsp_valid, mul_start, req_ready, mul_x, mul_y, ex, ey);
            end
        end
        @(negedge clk_in);
        mul_done    = 1'b0;
        mul_product = 8'($urandom);
        #1;
        checks++;
        if ({rsp_valid, rsp_product, rsp_err} !== {oh, 8'(exp_p), exp_err}) begin
            failures++;
            $display("FAIL response: valid=%b product=%0d err=%b expected valid=%b product=%0d err=%b",
                     rsp_valid, rsp_product, rsp_err, oh, exp_p, exp_err);
        end
        for (int b = 0; b < bp; b++) begin
            rsp_ready   = ~oh;
            mul_done    = spur;
            mul_product = 8'($urandom);
            @(negedge clk_in);
            #1;
            checks++;
            if ({rsp_valid, rsp_product, rsp_err, req_ready} !== {oh, 8'(exp_p), exp_err, N'(0)}) begin
                failures++;
                $display("FAIL hold_%0d: valid=%b product=%0d err=%b ready=%b expected %b/%0d/%b/0",
                         b, rsp_valid, rsp_product, rsp_err, req_ready, oh, exp_p, exp_err);
            end
        end
        rsp_ready = oh;
        mul_done  = 1'b0;
        @(negedge clk_in);
        rsp_ready = '0;
        #1;
        checks++;
        if ({rsp_valid, mul_start} !== {N'(0), 1'b0}) begin
            failures++;
            $display("FAIL release: rsp_valid=%b start=%b expected 0/0", rsp_valid, mul_start);
        end
        model_ptr = (g + 1) % N;
    endtask

    task automatic test_reset();
        rst_in    = 1'b0;
        req_valid = '1;
        mul_done  = 1'b1;
        repeat (2) @(negedge clk_in);
        #1;
        checks++;
        if ({req_ready, mul_start, mul_x, mul_y, rsp_valid, rsp_product, rsp_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b start=%b rsp_valid=%b product=%0d err=%b expected all 0",
                     req_ready, mul_start, rsp_valid, rsp_product, rsp_err);
        end
        mul_done = 1'b0;
        clear_pend();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        #1;
        checks++;
        if ({req_ready, mul_start, rsp_valid} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: ready=%b start=%b rsp_valid=%b expected 0",
                     req_ready, mul_start, rsp_valid);
        end
        model_ptr = 0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            px[i]   = $urandom_range(0, 15);
            py[i]   = $urandom_range(0, 15);
        end
        for (int t = 0; t < 5; t++) run_txn($urandom_range(1, 6), 0, 1'b1, 1'b0);
        clear_pend();
    endtask

    task automatic test_single();
        pend[1] = 1'b1; px[1] = 3; py[1] = 5;
        run_txn(3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        pend[0] = 1'b1; px[0] = 13; py[0] = 11;
        pend[3] = 1'b1; px[3] = 9;  py[3] = 14;
        run_txn(2, 5, 1'b0, 1'b0);
        run_txn(1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_watchdog();
        pend[2] = 1'b1; px[2] = 6; py[2] = 7;
        run_txn(-1, 1, 1'b0, 1'b0);
        pend[0] = 1'b1; px[0] = 15; py[0] = 2;
        run_txn(TO - 1, 0, 1'b0, 1'b0);
        pend[1] = 1'b1; px[1] = 12; py[1] = 12;
        run_txn(TO - 2, 0, 1'b0, 1'b0);
        pend[3] = 1'b1; px[3] = 4; py[3] = 10;
        run_txn(1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_wait();
        pend[2] = 1'b1; px[2] = 7; py[2] = 9;
        run_txn(2, 0, 1'b0, 1'b0);
        pend[2] = 1'b1; px[2] = 15; py[2] = 15;
        drive_reqs();
        @(negedge clk_in);
        @(negedge clk_in);
        @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        checks++;
        if ({req_ready, mul_start, mul_x, mul_y, rsp_valid, rsp_product, rsp_err} !== '0) begin
            failures++;
            $display("FAIL reset_in_wait: ready=%b start=%b x=%0d y=%0d rsp_valid=%b product=%0d expected all 0",
                     req_ready, mul_start, mul_x, mul_y, rsp_valid, rsp_product);
        end
        @(negedge clk_in);
        rst_in    = 1'b1;
        model_ptr = 0;
        pend[3] = 1'b1; px[3] = 5; py[3] = 3;
        run_txn(4, 0, 1'b0, 1'b0);
        run_txn(2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_spurious_done();
        clear_pend();
        for (int c = 0; c < 3; c++) begin
            mul_done    = 1'b1;
            mul_product = 8'($urandom_range(1, 255));
            @(negedge clk_in);
            #1;
            checks++;
            if ({rsp_valid, mul_start, req_ready} !== '0) begin
                failures++;
                $display("FAIL spurious_idle_%0d: rsp_valid=%b start=%b ready=%b expected 0",
                         c, rsp_valid, mul_start, req_ready);
            end
        end
        mul_done = 1'b0;
        pend[1] = 1'b1; px[1] = 2; py[1] = 9;
        run_txn(5, 3, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    px[i]   = $urandom_range(0, 15);
                    py[i]   = $urandom_range(0, 15);
                end
                any |= pend[i];
            end
            if (!any) begin
                int r;
                r = $urandom_range(0, N - 1);
                pend[r] = 1'b1; px[r] = $urandom_range(0, 15); py[r] = $urandom_range(0, 15);
            end
            run_txn($urandom_range(1, TO + 1), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        clear_pend();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; px[i] = 0; py[i] = 0;
        end
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_watchdog();
        test_reset_in_wait();
        test_spurious_done();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
